// File: rtl/fat32_pkg.sv
// Shared states, sector field offsets, error codes and captured-field layout
// for the FAT32 volume probe.
package fat32_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_REQ_MBR,
      ST_WAIT_MBR,
      ST_CHECK_MBR,
      ST_REQ_BPB,
      ST_WAIT_BPB,
      ST_CHECK_BPB,
      ST_COMPUTE,
      ST_DONE,
      ST_FAIL
   } state_e;

   // Byte offsets within a 512-byte sector (multi-byte fields are little-endian).
   localparam logic [8:0] OFS_BYTES_PER_SEC = 9'h00B;
   localparam logic [8:0] OFS_SEC_PER_CLUS  = 9'h00D;
   localparam logic [8:0] OFS_RSVD_SEC      = 9'h00E;
   localparam logic [8:0] OFS_NUM_FATS      = 9'h010;
   localparam logic [8:0] OFS_FAT_SIZE32    = 9'h024;
   localparam logic [8:0] OFS_ROOT_CLUS     = 9'h02C;
   localparam logic [8:0] OFS_PART_TYPE     = 9'h1C2;
   localparam logic [8:0] OFS_PART_LBA      = 9'h1C6;
   localparam logic [8:0] OFS_SIGNATURE     = 9'h1FE;

   localparam logic [2:0] ERR_NONE          = 3'd0;
   localparam logic [2:0] ERR_SIGNATURE     = 3'd1;
   localparam logic [2:0] ERR_BYTES_PER_SEC = 3'd2;
   localparam logic [2:0] ERR_SEC_PER_CLUS  = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT       = 3'd4;

   localparam logic [7:0]  PT_FAT32_CHS   = 8'h0B;
   localparam logic [7:0]  PT_FAT32_LBA   = 8'h0C;
   localparam logic [15:0] BOOT_SIGNATURE = 16'hAA55;

   typedef struct packed {
      logic [7:0]  part_type;
      logic [31:0] part_lba;
      logic [15:0] bytes_per_sec;
      logic [7:0]  sec_per_clus;
      logic [15:0] rsvd_sec;
      logic [7:0]  num_fats;
      logic [31:0] fat_size32;
      logic [31:0] root_clus;
      logic [15:0] signature;
   } fields_t;

   function automatic logic spc_is_valid(input logic [7:0] spc);
      return (spc != 8'd0) && ((spc & (spc - 8'd1)) == 8'd0);
   endfunction

endpackage

// File: rtl/sector_field_capture.sv
// Captures the MBR/BPB fields of interest from a streamed sector by matching
// each byte address against the known field offsets.
module sector_field_capture
   import fat32_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       enable,
   input  logic       byte_valid,
   input  logic [8:0] byte_address,
   input  logic [7:0] byte_data,
   output fields_t    fields
);

   fields_t fields_q, fields_d;

   always_comb begin
      fields_d = fields_q;
      if (clear) begin
         fields_d = '0;
      end else if (enable && byte_valid) begin
         case (byte_address)
            OFS_BYTES_PER_SEC:        fields_d.bytes_per_sec[7:0]  = byte_data;
            OFS_BYTES_PER_SEC + 9'd1: fields_d.bytes_per_sec[15:8] = byte_data;
            OFS_SEC_PER_CLUS:         fields_d.sec_per_clus        = byte_data;
            OFS_RSVD_SEC:             fields_d.rsvd_sec[7:0]       = byte_data;
            OFS_RSVD_SEC + 9'd1:      fields_d.rsvd_sec[15:8]      = byte_data;
            OFS_NUM_FATS:             fields_d.num_fats            = byte_data;
            OFS_FAT_SIZE32:           fields_d.fat_size32[7:0]     = byte_data;
            OFS_FAT_SIZE32 + 9'd1:    fields_d.fat_size32[15:8]    = byte_data;
            OFS_FAT_SIZE32 + 9'd2:    fields_d.fat_size32[23:16]   = byte_data;
            OFS_FAT_SIZE32 + 9'd3:    fields_d.fat_size32[31:24]   = byte_data;
            OFS_ROOT_CLUS:            fields_d.root_clus[7:0]      = byte_data;
            OFS_ROOT_CLUS + 9'd1:     fields_d.root_clus[15:8]     = byte_data;
            OFS_ROOT_CLUS + 9'd2:     fields_d.root_clus[23:16]    = byte_data;
            OFS_ROOT_CLUS + 9'd3:     fields_d.root_clus[31:24]    = byte_data;
            OFS_PART_TYPE:            fields_d.part_type           = byte_data;
            OFS_PART_LBA:             fields_d.part_lba[7:0]       = byte_data;
            OFS_PART_LBA + 9'd1:      fields_d.part_lba[15:8]      = byte_data;
            OFS_PART_LBA + 9'd2:      fields_d.part_lba[23:16]     = byte_data;
            OFS_PART_LBA + 9'd3:      fields_d.part_lba[31:24]     = byte_data;
            OFS_SIGNATURE:            fields_d.signature[7:0]      = byte_data;
            OFS_SIGNATURE + 9'd1:     fields_d.signature[15:8]     = byte_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) fields_q <= '0;
      else     fields_q <= fields_d;
   end

   assign fields = fields_q;

endmodule

// File: rtl/fat32_volume_probe.sv
// Reads sector 0 and, if it holds a FAT32 partition entry, the partition's
// boot sector; validates the BPB and derives the FAT and data region starts.
module fat32_volume_probe
   import fat32_pkg::*;
#(
   parameter int unsigned SectorBytes   = 512,
   parameter logic [31:0] TimeoutCycles = 32'd2_000_000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   output logic        ReadRequest,
   output logic [31:0] ReadSector,
   input  logic        ByteValid,
   input  logic [8:0]  ByteAddress,
   input  logic [7:0]  ByteData,
   input  logic        ReadDone,
   output logic [31:0] PartitionStart,
   output logic [7:0]  SectorsPerCluster,
   output logic [15:0] ReservedSectors,
   output logic [31:0] RootClusterNumber,
   output logic [31:0] FatStartSector,
   output logic [31:0] DataStartSector,
   output logic        Ready,
   output logic        Error,
   output logic [2:0]  ErrorCode,
   output state_e      DebugState
);

   state_e      state_q, state_d;
   logic        read_request_q, read_request_d;
   logic [31:0] read_sector_q, read_sector_d;
   logic [31:0] partition_start_q, partition_start_d;
   logic [7:0]  sec_per_clus_q, sec_per_clus_d;
   logic [15:0] rsvd_sec_q, rsvd_sec_d;
   logic [31:0] root_clus_q, root_clus_d;
   logic [31:0] fat_start_q, fat_start_d;
   logic [31:0] data_start_q, data_start_d;
   logic        ready_q, ready_d;
   logic        error_q, error_d;
   logic [2:0]  error_code_q, error_code_d;
   logic [31:0] watchdog_q, watchdog_d;

   logic    start_accept;
   logic    capture_enable;
   logic    timed_out;
   fields_t fields;

   assign start_accept   = Start && (state_q inside {ST_IDLE, ST_DONE, ST_FAIL});
   assign capture_enable = (state_q == ST_WAIT_MBR) || (state_q == ST_WAIT_BPB);
   // Counter is zero in the ReadRequest cycle, so this fires TimeoutCycles later.
   assign timed_out      = watchdog_q >= (TimeoutCycles - 32'd1);

   sector_field_capture u_capture (
      .clk          (Clock),
      .rst          (Reset),
      .clear        (start_accept),
      .enable       (capture_enable),
      .byte_valid   (ByteValid),
      .byte_address (ByteAddress),
      .byte_data    (ByteData),
      .fields       (fields)
   );

   always_comb begin
      state_d           = state_q;
      read_request_d    = 1'b0;
      read_sector_d     = read_sector_q;
      partition_start_d = partition_start_q;
      sec_per_clus_d    = sec_per_clus_q;
      rsvd_sec_d        = rsvd_sec_q;
      root_clus_d       = root_clus_q;
      fat_start_d       = fat_start_q;
      data_start_d      = data_start_q;
      ready_d           = ready_q;
      error_d           = error_q;
      error_code_d      = error_code_q;
      watchdog_d        = watchdog_q;

      if (state_q inside {ST_REQ_MBR, ST_WAIT_MBR, ST_REQ_BPB, ST_WAIT_BPB}) begin
         watchdog_d = watchdog_q + 32'd1;
      end

      case (state_q)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (Start) begin
               state_d           = ST_REQ_MBR;
               read_request_d    = 1'b1;
               read_sector_d     = 32'd0;
               watchdog_d        = 32'd0;
               partition_start_d = 32'd0;
               sec_per_clus_d    = 8'd0;
               rsvd_sec_d        = 16'd0;
               root_clus_d       = 32'd0;
               fat_start_d       = 32'd0;
               data_start_d      = 32'd0;
               ready_d           = 1'b0;
               error_d           = 1'b0;
               error_code_d      = ERR_NONE;
            end
         end
         ST_REQ_MBR: state_d = ST_WAIT_MBR;
         ST_WAIT_MBR: begin
            if (ReadDone) begin
               state_d = ST_CHECK_MBR;
            end else if (timed_out) begin
               state_d      = ST_FAIL;
               error_d      = 1'b1;
               error_code_d = ERR_TIMEOUT;
            end
         end
         ST_CHECK_MBR: begin
            if (fields.signature != BOOT_SIGNATURE) begin
               state_d      = ST_FAIL;
               error_d      = 1'b1;
               error_code_d = ERR_SIGNATURE;
            end else if (fields.part_type inside {PT_FAT32_CHS, PT_FAT32_LBA}) begin
               state_d           = ST_REQ_BPB;
               partition_start_d = fields.part_lba;
               read_sector_d     = fields.part_lba;
               read_request_d    = 1'b1;
               watchdog_d        = 32'd0;
            end else begin
               // Superfloppy: sector 0 itself is the boot sector, already captured.
               state_d           = ST_CHECK_BPB;
               partition_start_d = 32'd0;
            end
         end
         ST_REQ_BPB: state_d = ST_WAIT_BPB;
         ST_WAIT_BPB: begin
            if (ReadDone) begin
               state_d = ST_CHECK_BPB;
            end else if (timed_out) begin
               state_d      = ST_FAIL;
               error_d      = 1'b1;
               error_code_d = ERR_TIMEOUT;
            end
         end
         ST_CHECK_BPB: begin
            if (fields.signature != BOOT_SIGNATURE) begin
               state_d      = ST_FAIL;
               error_d      = 1'b1;
               error_code_d = ERR_SIGNATURE;
            end else if (fields.bytes_per_sec != 16'(SectorBytes)) begin
               state_d      = ST_FAIL;
               error_d      = 1'b1;
               error_code_d = ERR_BYTES_PER_SEC;
            end else if (!spc_is_valid(fields.sec_per_clus)) begin
               state_d      = ST_FAIL;
               error_d      = 1'b1;
               error_code_d = ERR_SEC_PER_CLUS;
            end else begin
               state_d = ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            state_d        = ST_DONE;
            ready_d        = 1'b1;
            sec_per_clus_d = fields.sec_per_clus;
            rsvd_sec_d     = fields.rsvd_sec;
            root_clus_d    = fields.root_clus;
            fat_start_d    = partition_start_q + 32'(fields.rsvd_sec);
            data_start_d   = partition_start_q + 32'(fields.rsvd_sec)
                             + (32'(fields.num_fats) * fields.fat_size32);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q           <= ST_IDLE;
         read_request_q    <= 1'b0;
         read_sector_q     <= 32'd0;
         partition_start_q <= 32'd0;
         sec_per_clus_q    <= 8'd0;
         rsvd_sec_q        <= 16'd0;
         root_clus_q       <= 32'd0;
         fat_start_q       <= 32'd0;
         data_start_q      <= 32'd0;
         ready_q           <= 1'b0;
         error_q           <= 1'b0;
         error_code_q      <= ERR_NONE;
         watchdog_q        <= 32'd0;
      end else begin
         state_q           <= state_d;
         read_request_q    <= read_request_d;
         read_sector_q     <= read_sector_d;
         partition_start_q <= partition_start_d;
         sec_per_clus_q    <= sec_per_clus_d;
         rsvd_sec_q        <= rsvd_sec_d;
         root_clus_q       <= root_clus_d;
         fat_start_q       <= fat_start_d;
         data_start_q      <= data_start_d;
         ready_q           <= ready_d;
         error_q           <= error_d;
         error_code_q      <= error_code_d;
         watchdog_q        <= watchdog_d;
      end
   end

   assign ReadRequest       = read_request_q;
   assign ReadSector        = read_sector_q;
   assign PartitionStart    = partition_start_q;
   assign SectorsPerCluster = sec_per_clus_q;
   assign ReservedSectors   = rsvd_sec_q;
   assign RootClusterNumber = root_clus_q;
   assign FatStartSector    = fat_start_q;
   assign DataStartSector   = data_start_q;
   assign Ready             = ready_q;
   assign Error             = error_q;
   assign ErrorCode         = error_code_q;
   assign DebugState        = state_q;

endmodule
